// File: rtl/alocador_na.sv
// Active-node slot manager: maps update/deactivate ops to a one-hot NA enable,
// allocating free slots from a lowest-index bitmap, with a one-cycle bypass for fresh allocations.
module alocador_na #(
    parameter int NUM_NA          = 8,
    parameter int ADDR_WIDTH      = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    localparam int LIVRES_WIDTH   = $clog2(NUM_NA + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         op_valid_in,
    input  logic                         op_desativar_in,
    output logic                         op_ready_out,
    input  logic                         flush_in,
    input  logic [ADDR_WIDTH-1:0]        endereco_in,
    input  logic [ADDR_WIDTH-1:0]        anterior_in,
    input  logic [CUSTO_WIDTH-1:0]       menor_vizinho_in,
    input  logic [DISTANCIA_WIDTH-1:0]   distancia_in,
    input  logic [ADDR_WIDTH*NUM_NA-1:0] na_endereco_in,
    input  logic [NUM_NA-1:0]            na_ativo_in,
    output logic                         ga_atualizar_out,
    output logic                         ga_desativar_out,
    output logic [NUM_NA-1:0]            ga_habilitar_out,
    output logic [ADDR_WIDTH-1:0]        ga_endereco_out,
    output logic [ADDR_WIDTH-1:0]        ga_anterior_out,
    output logic [CUSTO_WIDTH-1:0]       ga_menor_vizinho_out,
    output logic [DISTANCIA_WIDTH-1:0]   ga_distancia_out,
    output logic [LIVRES_WIDTH-1:0]      ga_livres_o,
    output logic                         ga_buffers_cheios_o,
    output logic                         ga_ocupado_o,
    output logic                         ga_erro_o
);

    function automatic logic [NUM_NA-1:0] lowest_oh(input logic [NUM_NA-1:0] v);
        logic seen;
        lowest_oh = '0;
        seen      = 1'b0;
        for (int i = 0; i < NUM_NA; i++) begin
            if (v[i] && !seen) begin
                lowest_oh[i] = 1'b1;
                seen         = 1'b1;
            end
        end
    endfunction

    function automatic logic [LIVRES_WIDTH-1:0] popcount(input logic [NUM_NA-1:0] v);
        popcount = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            popcount = popcount + LIVRES_WIDTH'(v[i]);
        end
    endfunction

    logic [NUM_NA-1:0]          livres_q, livres_d;
    logic                       byp_vld_q, byp_vld_d;
    logic [ADDR_WIDTH-1:0]      byp_addr_q, byp_addr_d;
    logic [NUM_NA-1:0]          byp_slot_q, byp_slot_d;
    logic                       erro_q, erro_d;
    logic                       atu_q, atu_d;
    logic                       des_q, des_d;
    logic [NUM_NA-1:0]          hab_q, hab_d;
    logic [ADDR_WIDTH-1:0]      end_q, end_d;
    logic [ADDR_WIDTH-1:0]      ant_q, ant_d;
    logic [CUSTO_WIDTH-1:0]     men_q, men_d;
    logic [DISTANCIA_WIDTH-1:0] dist_q, dist_d;

    logic [NUM_NA-1:0] hit, hit_low, sel_oh, free_oh;
    logic              hit_any, multi_hit, byp_hit, found, cheio, accept;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            hit[i] = na_ativo_in[i] && (na_endereco_in[i*ADDR_WIDTH +: ADDR_WIDTH] == endereco_in);
        end
    end

    // The bypass slot wins over the array because na_ativo_in lags a fresh allocation by a cycle.
    assign hit_low   = lowest_oh(hit);
    assign hit_any   = |hit;
    assign multi_hit = popcount(hit) > LIVRES_WIDTH'(1);
    assign byp_hit   = byp_vld_q && (byp_addr_q == endereco_in);
    assign sel_oh    = byp_hit ? byp_slot_q : hit_low;
    assign found     = byp_hit || hit_any;
    assign free_oh   = lowest_oh(livres_q);
    assign cheio     = (livres_q == '0);

    assign op_ready_out = !flush_in && !(!op_desativar_in && !found && cheio);
    assign accept       = op_valid_in && op_ready_out;

    always_comb begin
        livres_d   = livres_q;
        byp_vld_d  = 1'b0;
        byp_addr_d = byp_addr_q;
        byp_slot_d = byp_slot_q;
        erro_d     = erro_q;
        atu_d      = 1'b0;
        des_d      = 1'b0;
        hab_d      = '0;
        end_d      = end_q;
        ant_d      = ant_q;
        men_d      = men_q;
        dist_d     = dist_q;
        if (flush_in) begin
            livres_d = '1;
            erro_d   = 1'b0;
        end else if (accept) begin
            end_d  = endereco_in;
            ant_d  = anterior_in;
            men_d  = menor_vizinho_in;
            dist_d = distancia_in;
            if (!byp_hit && multi_hit) erro_d = 1'b1;
            if (op_desativar_in) begin
                des_d = 1'b1;
                if (found) begin
                    hab_d    = sel_oh;
                    livres_d = livres_q | sel_oh;
                end else begin
                    erro_d = 1'b1;
                end
            end else begin
                atu_d      = 1'b1;
                hab_d      = found ? sel_oh : free_oh;
                if (!found) livres_d = livres_q & ~free_oh;
                byp_vld_d  = 1'b1;
                byp_addr_d = endereco_in;
                byp_slot_d = found ? sel_oh : free_oh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            livres_q   <= '1;
            byp_vld_q  <= 1'b0;
            byp_addr_q <= '0;
            byp_slot_q <= '0;
            erro_q     <= 1'b0;
            atu_q      <= 1'b0;
            des_q      <= 1'b0;
            hab_q      <= '0;
            end_q      <= '0;
            ant_q      <= '0;
            men_q      <= '0;
            dist_q     <= '0;
        end else begin
            livres_q   <= livres_d;
            byp_vld_q  <= byp_vld_d;
            byp_addr_q <= byp_addr_d;
            byp_slot_q <= byp_slot_d;
            erro_q     <= erro_d;
            atu_q      <= atu_d;
            des_q      <= des_d;
            hab_q      <= hab_d;
            end_q      <= end_d;
            ant_q      <= ant_d;
            men_q      <= men_d;
            dist_q     <= dist_d;
        end
    end

    assign ga_atualizar_out     = atu_q;
    assign ga_desativar_out     = des_q;
    assign ga_habilitar_out     = hab_q;
    assign ga_endereco_out      = end_q;
    assign ga_anterior_out      = ant_q;
    assign ga_menor_vizinho_out = men_q;
    assign ga_distancia_out     = dist_q;
    assign ga_livres_o          = popcount(livres_q);
    assign ga_buffers_cheios_o  = cheio;
    assign ga_ocupado_o         = op_valid_in || atu_q || des_q;
    assign ga_erro_o            = erro_q;

endmodule
